// File: rtl/tx_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tx_frame_sequencer
//
// Transmit frame sequencer. It builds a frame of 1..2^WORD_W-1 words by
// walking the message generator, the shift-register loader and the UART-style
// transmitter through one-cycle start pulses and level done/ready handshakes.
// A programmable gap timer inserts a fixed pause between message generation
// and the first word of every frame. Frames can be chained back to back in
// continuous mode. A synchronous abort returns the sequencer to IDLE from any
// busy state. A free-running counter records how many frames have completed.
//
// Parameters
//   WORD_W      width of the word count and the word index
//   GAP_W       width of the pre-transmit gap timer
//   FCNT_W      width of the completed-frame counter
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      request frame(s); only looked at in IDLE and DONE
//   continuous  1 = chain frames while enable stays high, 0 = single shot
//   abort       synchronous abort, wins over everything outside IDLE
//   num_words   words per frame, captured at frame start (0 = no frame)
//   gap_cycles  gap timer load value, captured at frame start
//   msj_done    message generator finished (level)
//   sh_done     shift register loaded (level)
//   tx_ready    transmitter idle and able to take start_tx (level)
//   start_msj   one-cycle pulse, start message generation
//   start_sh    one-cycle pulse, load word word_idx into the shift register
//   start_tx    one-cycle pulse, transmit the loaded word
//   word_idx    0-based index of the word being handled
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse per completed frame
//   frame_cnt   completed-frame count, wraps silently
// ----------------------------------------------------------------------------
module tx_frame_sequencer #(
    parameter int WORD_W = 4,
    parameter int GAP_W  = 16,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              continuous,
    input  logic              abort,
    input  logic [WORD_W-1:0] num_words,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic              msj_done,
    input  logic              sh_done,
    input  logic              tx_ready,
    output logic              start_msj,
    output logic              start_sh,
    output logic              start_tx,
    output logic [WORD_W-1:0] word_idx,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [WORD_W-1:0] WORD_ONE = WORD_W'(1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_MSG_REQ  = 4'd1,
        ST_MSG_WAIT = 4'd2,
        ST_GAP      = 4'd3,
        ST_SH_LOAD  = 4'd4,
        ST_SH_WAIT  = 4'd5,
        ST_TX_WAIT  = 4'd6,
        ST_TX_START = 4'd7,
        ST_WORD_END = 4'd8,
        ST_DONE     = 4'd9
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] word_idx_q;
    logic [WORD_W-1:0] word_idx_d;
    logic [WORD_W-1:0] num_words_q;
    logic [WORD_W-1:0] num_words_d;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_d;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [FCNT_W-1:0] frame_cnt_d;
    logic              last_word;
    logic              frame_request;

    // The word index is compared against the frame length captured at frame
    // start, so host writes to num_words during a frame are invisible here.
    assign last_word = (word_idx_q == (num_words_q - WORD_ONE));

    // A new frame may only begin when the host asks for one with a non-zero
    // length; the same test gates both the IDLE start and the DONE chain.
    assign frame_request = enable && (num_words != '0);

    // State register. Only the state lives here so that the transition logic
    // below stays a single readable case statement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers that travel with the state: word index, captured
    // frame parameters, gap countdown and the completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_q  <= '0;
            num_words_q <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            word_idx_q  <= word_idx_d;
            num_words_q <= num_words_d;
            gap_q       <= gap_q == gap_d ? gap_q : gap_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state and next-datapath logic. Every register holds by default.
    // Abort is checked first so that a busy state can never advance, pulse
    // a handshake into the next cycle or count a frame in the abort cycle.
    // The gap timer is loaded on leaving MSG_WAIT and counted down in GAP,
    // giving gap+1 cycles in GAP; the gap runs once per frame, not per word.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        num_words_d = num_words_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            word_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_request) begin
                        num_words_d = num_words;
                        gap_d       = gap_cycles;
                        word_idx_d  = '0;
                        state_d     = ST_MSG_REQ;
                    end
                end
                ST_MSG_REQ: begin
                    state_d = ST_MSG_WAIT;
                end
                ST_MSG_WAIT: begin
                    if (msj_done) begin
                        gap_cnt_d = gap_q;
                        state_d   = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = ST_SH_LOAD;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_ONE;
                    end
                end
                ST_SH_LOAD: begin
                    state_d = ST_SH_WAIT;
                end
                ST_SH_WAIT: begin
                    if (sh_done) begin
                        state_d = ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    if (tx_ready) begin
                        state_d = ST_TX_START;
                    end
                end
                ST_TX_START: begin
                    state_d = ST_WORD_END;
                end
                ST_WORD_END: begin
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        word_idx_d = word_idx_q + WORD_ONE;
                        state_d    = ST_SH_LOAD;
                    end
                end
                ST_DONE: begin
                    frame_cnt_d = frame_cnt_q + FCNT_ONE;
                    if (continuous && frame_request) begin
                        num_words_d = num_words;
                        gap_d       = gap_cycles;
                        word_idx_d  = '0;
                        state_d     = ST_MSG_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    word_idx_d = '0;
                end
            endcase
        end
    end

    // Moore outputs: pure decodes of the registered state and counters.
    assign start_msj  = (state_q == ST_MSG_REQ);
    assign start_sh   = (state_q == ST_SH_LOAD);
    assign start_tx   = (state_q == ST_TX_START);
    assign frame_done = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign word_idx   = word_idx_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tx_frame_sequencer
//
// Self-checking bench for tx_frame_sequencer: a per-cycle vector table for a
// single-shot frame, hand-written sequences for reset, handshake stalls,
// continuous chaining, abort and frame-length corner cases, then a long run
// of random inputs compared cycle by cycle against a procedural model that
// walks through a frame the way the block is described: request, wait, gap,
// then per word load / wait / transmit, then done.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx_frame_sequencer;

    localparam int WORD_W = 4;
    localparam int GAP_W  = 16;
    localparam int FCNT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              continuous = 1'b0;
    logic              abort = 1'b0;
    logic [WORD_W-1:0] num_words = '0;
    logic [GAP_W-1:0]  gap_cycles = '0;
    logic              msj_done = 1'b0;
    logic              sh_done = 1'b0;
    logic              tx_ready = 1'b0;
    logic              start_msj;
    logic              start_sh;
    logic              start_tx;
    logic [WORD_W-1:0] word_idx;
    logic              busy;
    logic              frame_done;
    logic [FCNT_W-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int n_msj = 0;
    int n_sh  = 0;
    int n_tx  = 0;
    int n_fd  = 0;

    tx_frame_sequencer #(
        .WORD_W(WORD_W),
        .GAP_W (GAP_W),
        .FCNT_W(FCNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .continuous(continuous),
        .abort     (abort),
        .num_words (num_words),
        .gap_cycles(gap_cycles),
        .msj_done  (msj_done),
        .sh_done   (sh_done),
        .tx_ready  (tx_ready),
        .start_msj (start_msj),
        .start_sh  (start_sh),
        .start_tx  (start_tx),
        .word_idx  (word_idx),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case a sequence loses track of the DUT.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One table row: the inputs driven for a cycle and the outputs required
    // in the cycle that follows the next rising edge.
    typedef struct {
        logic              enable;
        logic [WORD_W-1:0] num_words;
        logic [GAP_W-1:0]  gap_cycles;
        logic              e_msj;
        logic              e_sh;
        logic              e_tx;
        logic [WORD_W-1:0] e_idx;
        logic              e_busy;
        logic              e_fd;
        logic [FCNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model state and the outputs it predicts for the current cycle.
    logic              model_go = 1'b0;
    logic              e_msj = 1'b0;
    logic              e_sh = 1'b0;
    logic              e_tx = 1'b0;
    logic              e_fd = 1'b0;
    logic              e_busy = 1'b0;
    logic [WORD_W-1:0] e_idx = '0;
    logic [FCNT_W-1:0] e_cnt = '0;
    logic [WORD_W-1:0] m_idx = '0;
    logic [FCNT_W-1:0] m_cnt = '0;
    logic [WORD_W-1:0] m_lat_n = '0;
    logic [GAP_W-1:0]  m_lat_g = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        enable     = v.enable;
        num_words  = v.num_words;
        gap_cycles = v.gap_cycles;
        msj_done   = 1'b1;
        sh_done    = 1'b1;
        tx_ready   = 1'b1;
        continuous = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic applyRandomStimulus();
        enable     = ($urandom_range(0, 3) != 0);
        continuous = $urandom_range(0, 1) == 1;
        abort      = ($urandom_range(0, 49) == 0);
        num_words  = WORD_W'($urandom_range(0, 4));
        gap_cycles = GAP_W'($urandom_range(0, 3));
        msj_done   = ($urandom_range(0, 9) < 6);
        sh_done    = ($urandom_range(0, 9) < 6);
        tx_ready   = ($urandom_range(0, 9) < 6);
    endtask

    // Advance one cycle and tally the pulses seen in the new cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n_msj += int'(start_msj);
        n_sh  += int'(start_sh);
        n_tx  += int'(start_tx);
        n_fd  += int'(frame_done);
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        continuous = 1'b0;
        abort      = 1'b0;
        num_words  = '0;
        gap_cycles = '0;
        msj_done   = 1'b1;
        sh_done    = 1'b1;
        tx_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_msj = 0;
        n_sh  = 0;
        n_tx  = 0;
        n_fd  = 0;
    endtask

    task automatic waitSh(input int idx, input int limit, input string name);
        int n;
        n = 0;
        while (!(start_sh && (int'(word_idx) == idx)) && (n < limit)) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, start_sh && (int'(word_idx) == idx)}, 32'd1);
    endtask

    task automatic waitTx(input int idx, input int limit, input string name);
        int n;
        n = 0;
        while (!(start_tx && (int'(word_idx) == idx)) && (n < limit)) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, start_tx && (int'(word_idx) == idx)}, 32'd1);
    endtask

    task automatic waitIdle(input int limit, input string name);
        int n;
        n = 0;
        while (busy && (n < limit)) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic addVec(input logic en, input logic msj, input logic sh, input logic tx,
                          input int idx, input logic bsy, input logic fd, input int cnt);
        vec_t v;
        v.enable     = en;
        v.num_words  = WORD_W'(3);
        v.gap_cycles = GAP_W'(2);
        v.e_msj      = msj;
        v.e_sh       = sh;
        v.e_tx       = tx;
        v.e_idx      = WORD_W'(idx);
        v.e_busy     = bsy;
        v.e_fd       = fd;
        v.e_cnt      = FCNT_W'(cnt);
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // Publishes the outputs expected for one cycle, then lets the edge pass
    // and reports whether an abort was taken at that edge.
    task automatic mCycle(input logic msj, input logic sh, input logic tx, input logic fd,
                          input logic bsy, output logic ab);
        e_msj  = msj;
        e_sh   = sh;
        e_tx   = tx;
        e_fd   = fd;
        e_busy = bsy;
        e_idx  = m_idx;
        e_cnt  = m_cnt;
        @(posedge clk);
        ab = bsy && abort;
        if (ab) m_idx = '0;
    endtask

    // One frame from the start request to the done cycle; returns early on
    // abort. chain reports whether another frame follows immediately.
    task automatic modelFrame(output logic chain);
        logic ab;
        int   nw;
        int   g;
        nw    = int'(m_lat_n);
        g     = int'(m_lat_g);
        chain = 1'b0;
        m_idx = '0;
        mCycle(1, 0, 0, 0, 1, ab);
        if (ab) return;
        forever begin
            mCycle(0, 0, 0, 0, 1, ab);
            if (ab) return;
            if (msj_done) break;
        end
        for (int k = 0; k <= g; k++) begin
            mCycle(0, 0, 0, 0, 1, ab);
            if (ab) return;
        end
        for (int w = 0; w < nw; w++) begin
            m_idx = WORD_W'(w);
            mCycle(0, 1, 0, 0, 1, ab);
            if (ab) return;
            forever begin
                mCycle(0, 0, 0, 0, 1, ab);
                if (ab) return;
                if (sh_done) break;
            end
            forever begin
                mCycle(0, 0, 0, 0, 1, ab);
                if (ab) return;
                if (tx_ready) break;
            end
            mCycle(0, 0, 1, 0, 1, ab);
            if (ab) return;
            mCycle(0, 0, 0, 0, 1, ab);
            if (ab) return;
        end
        mCycle(0, 0, 0, 1, 1, ab);
        if (ab) return;
        m_cnt = m_cnt + FCNT_W'(1);
        if (continuous && enable && (num_words != '0)) begin
            m_lat_n = num_words;
            m_lat_g = gap_cycles;
            chain   = 1'b1;
        end
    endtask

    // Model process: idles until asked for a frame, then runs frames.
    initial begin
        logic chain;
        logic ab;
        chain = 1'b0;
        wait (model_go);
        forever begin
            if (chain) begin
                modelFrame(chain);
            end else begin
                mCycle(0, 0, 0, 0, 0, ab);
                if (enable && (num_words != '0)) begin
                    m_lat_n = num_words;
                    m_lat_g = gap_cycles;
                    chain   = 1'b1;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int snap_msj;
        int snap_sh;
        int snap_tx;
        int snap_fd;
        int guard;
        int busy_cycles;
        logic prev_fd;

        // Reset state and asynchronous reset in the middle of a gap.
        doReset();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_word_idx", {28'd0, word_idx}, 32'd0);
        checkOutput("reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        enable = 1'b1; num_words = 4'd1; gap_cycles = 16'd5;
        tick();
        enable = 1'b0;
        tick();
        tick();
        checkOutput("gap_busy_before_reset", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {25'd0, start_msj, start_sh, start_tx, busy, frame_done, word_idx == '0,
                     frame_cnt == '0}, 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        snap_msj = n_msj; snap_sh = n_sh; snap_tx = n_tx; snap_fd = n_fd;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("post_reset_quiet_pulses",
                    n_msj + n_sh + n_tx + n_fd - snap_msj - snap_sh - snap_tx - snap_fd, 0);
        checkOutput("post_reset_quiet_busy", {31'd0, busy}, 32'd0);

        // Table-driven single shot: 3 words, gap 2, handshakes tied high.
        doReset();
        addVec(1, 1, 0, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) addVec(0, 0, 0, 0, 0, 1, 0, 0);
        for (int w = 0; w < 3; w++) begin
            addVec(0, 0, 1, 0, w, 1, 0, 0);
            addVec(0, 0, 0, 0, w, 1, 0, 0);
            addVec(0, 0, 0, 0, w, 1, 0, 0);
            addVec(0, 0, 0, 1, w, 1, 0, 0);
            addVec(0, 0, 0, 0, w, 1, 0, 0);
        end
        addVec(0, 0, 0, 0, 2, 1, 1, 0);
        addVec(0, 0, 0, 0, 2, 0, 0, 1);
        addVec(0, 0, 0, 0, 2, 0, 0, 1);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d_start_msj", i), {31'd0, start_msj}, {31'd0, vecs[i].e_msj});
            checkOutput($sformatf("vec%0d_start_sh", i), {31'd0, start_sh}, {31'd0, vecs[i].e_sh});
            checkOutput($sformatf("vec%0d_start_tx", i), {31'd0, start_tx}, {31'd0, vecs[i].e_tx});
            checkOutput($sformatf("vec%0d_word_idx", i), {28'd0, word_idx}, {28'd0, vecs[i].e_idx});
            checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            checkOutput($sformatf("vec%0d_frame_done", i), {31'd0, frame_done}, {31'd0, vecs[i].e_fd});
            checkOutput($sformatf("vec%0d_frame_cnt", i), {24'd0, frame_cnt}, {24'd0, vecs[i].e_cnt});
        end

        // Transmitter stall on word 1: stays in TX_WAIT, one start_tx after release.
        doReset();
        enable = 1'b1; num_words = 4'd2; gap_cycles = 16'd0;
        tick();
        enable = 1'b0;
        waitTx(0, 20, "stall_word0_tx");
        tx_ready = 1'b0;
        waitSh(1, 20, "stall_word1_sh");
        snap_tx = n_tx;
        for (int i = 0; i < 12; i++) tick();
        checkOutput("stall_no_tx", n_tx - snap_tx, 0);
        checkOutput("stall_busy", {31'd0, busy}, 32'd1);
        checkOutput("stall_word_idx", {28'd0, word_idx}, 32'd1);
        tx_ready = 1'b1;
        tick();
        checkOutput("stall_tx_after_ready", {31'd0, start_tx}, 32'd1);
        waitIdle(20, "stall_end_idle");
        checkOutput("stall_one_tx_word1", n_tx - snap_tx, 1);
        checkOutput("stall_frames", n_fd, 1);

        // Continuous mode: three chained frames, enable dropped in the third.
        doReset();
        enable = 1'b1; continuous = 1'b1; num_words = 4'd2; gap_cycles = 16'd0;
        guard = 0;
        prev_fd = 1'b0;
        while ((n_fd < 3) && (guard < 200)) begin
            tick();
            guard++;
            if (prev_fd) begin
                checkOutput("chain_start_msj", {31'd0, start_msj}, 32'd1);
                checkOutput("chain_busy", {31'd0, busy}, 32'd1);
            end
            prev_fd = frame_done;
            if ((n_fd == 2) && start_msj) enable = 1'b0;
        end
        checkOutput("cont_frames", n_fd, 3);
        tick();
        checkOutput("cont_end_busy", {31'd0, busy}, 32'd0);
        checkOutput("cont_end_msj", {31'd0, start_msj}, 32'd0);
        checkOutput("cont_frame_cnt", {24'd0, frame_cnt}, 32'd3);
        checkOutput("cont_msj_count", n_msj, 3);

        // Abort while waiting for the shift register on word 1 of 4.
        doReset();
        enable = 1'b1; num_words = 4'd4; gap_cycles = 16'd1;
        tick();
        enable = 1'b0;
        waitSh(1, 40, "abort_reach_word1");
        sh_done = 1'b0;
        tick();
        checkOutput("abort_pre_busy", {31'd0, busy}, 32'd1);
        checkOutput("abort_pre_idx", {28'd0, word_idx}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sh_done = 1'b1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_idx", {28'd0, word_idx}, 32'd0);
        checkOutput("abort_fd", {31'd0, frame_done}, 32'd0);
        snap_msj = n_msj; snap_sh = n_sh; snap_tx = n_tx; snap_fd = n_fd;
        for (int i = 0; i < 15; i++) tick();
        checkOutput("abort_no_pulses",
                    n_msj + n_sh + n_tx + n_fd - snap_msj - snap_sh - snap_tx - snap_fd, 0);
        checkOutput("abort_frame_cnt", {24'd0, frame_cnt}, 32'd0);

        // Zero-length request is ignored (abort in IDLE too); mid-frame length change.
        doReset();
        enable = 1'b1; num_words = 4'd0; abort = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            busy_cycles += int'(busy);
        end
        checkOutput("zero_len_busy_cycles", busy_cycles, 0);
        checkOutput("zero_len_msj", n_msj, 0);
        abort = 1'b0; num_words = 4'd2; gap_cycles = 16'd0;
        tick();
        checkOutput("len_change_start", {31'd0, start_msj}, 32'd1);
        num_words = 4'd5;
        enable = 1'b0;
        waitIdle(60, "len_change_idle");
        checkOutput("len_change_tx_count", n_tx, 2);
        checkOutput("len_change_sh_count", n_sh, 2);
        checkOutput("len_change_frames", {24'd0, frame_cnt}, 32'd1);

        // Random inputs against the reference model.
        doReset();
        applyRandomStimulus();
        model_go = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rnd_start_msj", {31'd0, start_msj}, {31'd0, e_msj});
            checkOutput("rnd_start_sh", {31'd0, start_sh}, {31'd0, e_sh});
            checkOutput("rnd_start_tx", {31'd0, start_tx}, {31'd0, e_tx});
            checkOutput("rnd_frame_done", {31'd0, frame_done}, {31'd0, e_fd});
            checkOutput("rnd_busy", {31'd0, busy}, {31'd0, e_busy});
            checkOutput("rnd_word_idx", {28'd0, word_idx}, {28'd0, e_idx});
            checkOutput("rnd_frame_cnt", {24'd0, frame_cnt}, {24'd0, e_cnt});
            applyRandomStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
